reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin write arbiter in front of a bank of enable-gated D flip-flop registers.
- Shares the bank's single write datapath (common D bus plus per-register enable) between NREQ requesters.
- One registered write pulse per arbitration.
- Sits between requesting masters and the register bank; drives each register's D and en inputs directly.

Parameters:
- NREQ, 4: number of requesters (2..8).
- NREG, 4: number of registers in the bank.
- AW, 2: address width; NREG <= 2**AW.
- DW, 8: data width of each register / the D bus.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request; held high until its gnt.
- wr_addr  in  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- wr_data  in  NREQ*DW  flattened data; requester i uses bits [i*DW +: DW].
- gnt  out  NREQ  one-hot, one-cycle grant/acknowledge pulse.
- reg_en  out  NREG  one-hot, one-cycle enable to the bank registers.
- reg_d  out  DW  data bus to all bank registers.
- busy  out  1  high while in WRITE state.
- err  out  1  one-cycle pulse: granted address >= NREG.

Behaviour:
- Reset:
  - rst high forces state=IDLE, ptr=0, and gnt=0, reg_en=0, reg_d=0, busy=0, err=0 immediately (asynchronous).
  - Reset mid-WRITE aborts the write; no enable survives.
- FSM, two states: IDLE, WRITE.
- IDLE, at a rising edge with |req=1:
  - Winner w = first set req bit searching ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1.
  - Register gnt=onehot(w) and reg_d=wr_data[w].
  - Register reg_en=onehot(wr_addr[w]) if wr_addr[w] < NREG; else reg_en=0 and err=1.
  - Register busy=1; ptr <= (w+1) mod NREQ; state <= WRITE.
- IDLE with req=0: outputs stay 0; ptr unchanged.
- WRITE:
  - Lasts exactly one cycle; the bank captures reg_d on the next rising edge.
  - At that edge: gnt, reg_en, err, busy return to 0; state <= IDLE.
  - reg_d holds its last value; it is don't-care when reg_en=0.
- All outputs are registered; no combinational path from req, wr_addr or wr_data to any output.
- Latency: req sampled at edge E; gnt/reg_en high during cycle E..E+1; bank updates at E+1.
- Throughput: at most one write per 2 cycles. The next arbitration is at E+2.
- Handshake:
  - Requester deasserts req (or presents new addr/data) after observing gnt.
  - A req still high at E+2 is treated as a new request.
  - addr/data are sampled only at the arbitration edge; later changes do not affect the write in flight.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants of others.
- A req asserted during WRITE is not lost; it is considered at the next IDLE edge.
- Width rules:
  - ptr is AW-independent, sized to cover NREQ-1.
  - The wrap from NREQ-1 to 0 is explicit, with no reliance on power-of-two NREQ.
- Error case: a request whose address is >= NREG is still granted, so the requester never stalls. err pulses with gnt and no register is modified.

Test Plan:
- Reset values: assert rst mid-cycle with req=4'b1111 -> all outputs 0 immediately. After release with req=0 for 5 cycles -> gnt, reg_en and busy stay 0.
- Single write: req=4'b0100, wr_addr[2]=3, wr_data[2]=8'hA5 at edge E -> during E..E+1, gnt=4'b0100, reg_en=4'b1000, reg_d=8'hA5, busy=1. Attached bank reg3=8'hA5 after E+1; other registers unchanged.
- Round robin: req=4'b1111 held constant -> grant sequence 0001, 0010, 0100, 1000, 0001 on every second cycle, each one cycle wide.
- Pointer skip and wrap: after grant to requester 2 (ptr=3), req=4'b0011 -> next gnt=4'b0001, then 4'b0010.
- Out-of-range address: NREG=3, requester 1 with wr_addr=3 -> gnt=4'b0010, err=1, reg_en=0 for one cycle; bank contents unchanged.
- Reset mid-WRITE: assert rst during the cycle reg_en=4'b0001 -> reg_en drops before the next edge, target register not written. After release, ptr=0, so req=4'b1001 grants requester 0 first.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter feeding the shared D bus and per-register enables
// of an enable-gated register bank; one registered write pulse per arbitration.
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*DW-1:0] wr_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    reg_en,
  output logic [DW-1:0]      reg_d,
  output logic               busy,
  output logic               err,
  output logic               fsm_state
);

  // Handshake: a requester holds req (with stable addr/data) until it sees its
  // one-cycle gnt pulse; addr/data are sampled only on the arbitration edge, and
  // a req still high two edges later is treated as a fresh request.

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt, win;
  logic [PW:0]     idx;
  logic            found;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREQ-1:0] gnt_nxt;
  logic [NREG-1:0] en_nxt;
  logic [DW-1:0]   d_nxt;
  logic            busy_nxt, err_nxt;

  assign fsm_state = logic'(state);

  // Rotating priority search; the extra idx bit lets ptr+k exceed NREQ-1 before
  // the explicit wrap, so non-power-of-two NREQ works.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign win_addr = wr_addr[int'(win)*AW +: AW];
  assign win_data = wr_data[int'(win)*DW +: DW];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    en_nxt    = '0;
    d_nxt     = reg_d;
    busy_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = WRITE;
          gnt_nxt[win]  = 1'b1;
          d_nxt         = win_data;
          busy_nxt      = 1'b1;
          err_nxt       = int'(win_addr) >= NREG;
          ptr_nxt       = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
          for (int r = 0; r < NREG; r++) en_nxt[r] = (int'(win_addr) == r);
        end
      end
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      reg_en <= '0;
      reg_d  <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      reg_en <= en_nxt;
      reg_d  <= d_nxt;
      busy   <= busy_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: two instances (4- and 3-register banks) on shared
// inputs, table vectors, hand-written corner sequences and randomized traffic.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  gnt4, gnt3, en4;
  logic [2:0]  en3;
  logic [7:0]  d4, d3;
  logic        busy4, busy3, err4, err3, st4, st3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.NREQ(4), .NREG(4), .AW(2), .DW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt4), .reg_en(en4), .reg_d(d4), .busy(busy4), .err(err4), .fsm_state(st4)
  );

  reg_write_arbiter #(.NREQ(4), .NREG(3), .AW(2), .DW(8)) dut3 (
    .clk(clk), .rst(rst), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt3), .reg_en(en3), .reg_d(d3), .busy(busy3), .err(err3), .fsm_state(st3)
  );

  // Register banks driven by the arbiters
  logic [7:0] bank4[4];
  logic [7:0] bank3[3];
  logic       bank_clr;

  always @(posedge clk) begin
    if (bank_clr) begin
      for (int r = 0; r < 4; r++) bank4[r] <= 8'h00;
      for (int r = 0; r < 3; r++) bank3[r] <= 8'h00;
    end else begin
      for (int r = 0; r < 4; r++) if (en4[r]) bank4[r] <= d4;
      for (int r = 0; r < 3; r++) if (en3[r]) bank3[r] <= d3;
    end
  end

  // Reference model: grant bookkeeping plus expected bank contents
  int         m_ptr;
  bit         m_busy;
  int         p_addr;
  logic [7:0] p_data;
  logic [3:0] e_gnt, e_en4;
  logic [2:0] e_en3;
  logic [7:0] e_d;
  logic       e_busy, e_err4, e_err3;
  logic [7:0] exp_bank4[4];
  logic [7:0] exp_bank3[3];
  logic [3:0] exp_q[$];

  task automatic model_outputs_idle();
    e_gnt = '0; e_en4 = '0; e_en3 = '0; e_busy = 1'b0; e_err4 = 1'b0; e_err3 = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy = 1'b0; e_d = 8'h00;
    model_outputs_idle();
  endtask

  task automatic model_step();
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (p_addr < 4) exp_bank4[p_addr] = p_data;
      if (p_addr < 3) exp_bank3[p_addr] = p_data;
      m_busy = 1'b0;
      model_outputs_idle();
    end else if (req != 4'b0) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      p_addr = int'(wr_addr[w*2 +: 2]);
      p_data = wr_data[w*8 +: 8];
      e_gnt  = 4'(1 << w);
      e_d    = p_data;
      e_en4  = 4'(1 << p_addr);
      e_err4 = 1'b0;
      e_en3  = (p_addr < 3) ? 3'(1 << p_addr) : 3'b000;
      e_err3 = (p_addr >= 3);
      e_busy = 1'b1;
      m_busy = 1'b1;
      m_ptr  = (w + 1) % 4;
    end else begin
      model_outputs_idle();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt4"}, 32'(gnt4), 32'(e_gnt));
    chk({tag, ".gnt3"}, 32'(gnt3), 32'(e_gnt));
    chk({tag, ".en4"}, 32'(en4), 32'(e_en4));
    chk({tag, ".en3"}, 32'(en3), 32'(e_en3));
    chk({tag, ".d4"}, 32'(d4), 32'(e_d));
    chk({tag, ".d3"}, 32'(d3), 32'(e_d));
    chk({tag, ".busy4"}, 32'(busy4), 32'(e_busy));
    chk({tag, ".busy3"}, 32'(busy3), 32'(e_busy));
    chk({tag, ".state"}, 32'({st4, st3}), 32'({e_busy, e_busy}));
    chk({tag, ".err4"}, 32'(err4), 32'(e_err4));
    chk({tag, ".err3"}, 32'(err3), 32'(e_err3));
    chk({tag, ".bank4"}, {bank4[3], bank4[2], bank4[1], bank4[0]},
        {exp_bank4[3], exp_bank4[2], exp_bank4[1], exp_bank4[0]});
    chk({tag, ".bank3"}, 32'({bank3[2], bank3[1], bank3[0]}),
        32'({exp_bank3[2], exp_bank3[1], exp_bank3[0]}));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_en;
    logic [7:0]  exp_d;
    logic        exp_busy;
  } vec_t;

  vec_t tv[6];
  logic [23:0] b3_before;
  logic [7:0]  b0_before;

  initial begin
    tv[0] = '{4'b0100, 8'h30, 32'h00A5_0000, 4'b0100, 4'b1000, 8'hA5, 1'b1};
    tv[1] = '{4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 4'b0000, 8'hA5, 1'b0};
    tv[2] = '{4'b0011, 8'hE4, 32'h4433_2211, 4'b0001, 4'b0001, 8'h11, 1'b1};
    tv[3] = '{4'b0011, 8'hE4, 32'h4433_2211, 4'b0000, 4'b0000, 8'h11, 1'b0};
    tv[4] = '{4'b0011, 8'hE4, 32'h4433_2211, 4'b0010, 4'b0010, 8'h22, 1'b1};
    tv[5] = '{4'b0000, 8'hE4, 32'h4433_2211, 4'b0000, 4'b0000, 8'h22, 1'b0};

    req = '0; wr_addr = '0; wr_data = '0;
    bank_clr = 1'b1;
    model_reset();
    for (int r = 0; r < 4; r++) exp_bank4[r] = 8'h00;
    for (int r = 0; r < 3; r++) exp_bank3[r] = 8'h00;
    repeat (2) @(negedge clk);
    bank_clr = 1'b0;
    rst = 1'b0;

    // Asynchronous reset right after an arbitration with all requesters active
    req = 4'b1111; wr_addr = 8'hE4; wr_data = 32'h4433_2211;
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("rst_async");
    @(negedge clk);
    rst = 1'b0; req = '0;
    repeat (5) cycle("rst_idle");

    // Single write, pointer skip and wrap
    for (int i = 0; i < 6; i++) begin
      req = tv[i].req; wr_addr = tv[i].addr; wr_data = tv[i].data;
      cycle("tbl");
      chk("tbl_gnt", 32'(gnt4), 32'(tv[i].exp_gnt));
      chk("tbl_en", 32'(en4), 32'(tv[i].exp_en));
      chk("tbl_d", 32'(d4), 32'(tv[i].exp_d));
      chk("tbl_busy", 32'(busy4), 32'(tv[i].exp_busy));
    end
    chk("bank_reg3", 32'(bank4[3]), 32'h0000_00A5);
    chk("bank_reg2", 32'(bank4[2]), 32'h0000_0000);

    // Out-of-range address on the 3-register instance
    b3_before = {bank3[2], bank3[1], bank3[0]};
    req = 4'b0010; wr_addr = 8'h0C; wr_data = 32'h0000_BB00;
    cycle("oor");
    chk("oor_gnt", 32'(gnt3), 32'b0010);
    chk("oor_err", 32'(err3), 32'd1);
    chk("oor_en", 32'(en3), 32'd0);
    req = '0;
    cycle("oor_after");
    chk("oor_bank", 32'({bank3[2], bank3[1], bank3[0]}), 32'(b3_before));
    chk("oor_bank4", 32'(bank4[3]), 32'h0000_00BB);

    // Round robin with all requesters held
    sync_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111; wr_addr = 8'hE4; wr_data = 32'h4433_2211;
    for (int i = 0; i < 10; i++) begin
      cycle("rr");
      if (gnt4 != 4'b0) begin
        if (exp_q.size() == 0) chk("rr_extra", 32'(gnt4), 32'd0);
        else chk("rr_order", 32'(gnt4), 32'(exp_q.pop_front()));
      end
    end
    chk("rr_left", 32'(exp_q.size()), 32'd0);
    req = '0;
    cycle("rr_end");

    // Reset during the WRITE cycle
    b0_before = bank4[0];
    req = 4'b0001; wr_addr = 8'h00; wr_data = 32'h0000_005A;
    @(posedge clk);
    model_step();
    #1 chk("mw_en", 32'(en4), 32'b0001);
    #1 rst = 1'b1;
    model_reset();
    #1 chk("mw_en_drop", 32'(en4), 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 4'b1001; wr_addr = 8'hE4; wr_data = 32'h4433_2211;
    cycle("mw");
    chk("mw_bank0", 32'(bank4[0]), 32'(b0_before));
    chk("mw_gnt", 32'(gnt4), 32'b0001);
    req = '0;
    cycle("mw_end");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) sync_reset();
      req     = 4'($urandom_range(0, 15));
      wr_addr = 8'($urandom);
      wr_data = $urandom;
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
